io_pattern_engine: RTL
======================

// Module: io_pattern_engine
// PURPOSE
//   Parametrised, registered successor to the pad-level inverter stage in the tile top.
//   Samples a WIDTH-bit input bus through a synchroniser and drives a registered output bus.
//   The output bus is produced in one of four modes: invert, counter, LFSR, or rotate.
//   A shared prescaler paces the stepping modes.
//   Instantiated by the tile top between ui_in and uo_out.
// PARAMETERS
//   WIDTH        8       data bus width (>=2)
//   DIV          4       prescaler period in enabled cycles (>=1); tick every DIV cycles
//   SYNC_STAGES  2       input synchroniser depth (>=1)
//   TAPS         8'hB8   Galois LFSR feedback mask, WIDTH bits
// PORTS
//   clk     in   1      clock
//   rst_n   in   1      asynchronous active-low reset
//   ena     in   1      global enable; low freezes all state
//   din     in   WIDTH  raw input bus (asynchronous to clk)
//   mode    in   2      00 INVERT, 01 COUNT, 10 LFSR, 11 ROTATE
//   load    in   1      single-cycle request: dout <= din_s
//   dout    out  WIDTH  registered pattern output
//   tick    out  1      one-cycle pulse at prescaler wrap
//   irq     out  1      input-change pulse (see CONFIGURATION)
// BEHAVIOUR
//   - One clock, clk. rst_n is asynchronous and active-low.
//   - Reset values: dout=0, tick=0, irq=0, prescaler=0, synchroniser flops=0, mode_q=00.
//   - Synchroniser: din_s = din delayed by SYNC_STAGES flops. Always runs, even when ena=0.
//   - ena=0:
//     - prescaler, dout, and mode_q hold their values;
//     - tick=0 and irq=0.
//   - Prescaler (counts only when ena=1):
//     - counts 0..DIV-1, then wraps to 0;
//     - tick=1 in the cycle the count is DIV-1;
//     - DIV=1 gives tick=1 on every enabled cycle.
//   - mode is registered into mode_q.
//     - When mode != mode_q, the prescaler clears to 0 and dout holds for that cycle.
//     - The new mode acts from the following cycle.
//   - Update priority per enabled cycle:
//     - 1) load;
//     - 2) mode change (hold);
//     - 3) mode action.
//   - load=1: dout <= din_s in every mode. The prescaler is not affected.
//   - INVERT: dout <= ~din_s every enabled cycle. Latency din->dout = SYNC_STAGES+1 cycles.
//   - COUNT: on tick, dout <= dout+1 mod 2^WIDTH. 2^WIDTH-1 wraps to 0 with no flag.
//   - LFSR: on tick:
//     - dout <= (dout>>1) ^ (dout[0] ? TAPS : 0);
//     - if dout==0, it steps to 1 instead (lock-up escape).
//   - ROTATE: on tick, dout <= {dout[WIDTH-2:0], dout[WIDTH-1]}. dout==0 stays 0.
//   - Reset mid-operation: all state returns to reset values immediately. No partial step.
// CONFIGURATION
//   - Macro IO_PATTERN_IRQ_EN.
//   - Defined:
//     - irq=1 for exactly one cycle when din_s differs from its previous-cycle value
//       while ena=1;
//     - one extra flop stage holds the previous din_s;
//     - irq is registered, so it appears 1 cycle after the change reaches din_s.
//   - Undefined: irq is tied to 0, and no extra flops are built.
// TESTING
//   - Reset with mode=00 and din=8'h0F: dout=0 during reset. dout=8'hF0 SYNC_STAGES+1 cycles
//     after release.
//   - mode=01, DIV=4, 1024 cycles with ena=1: tick every 4th cycle. dout goes
//     0..255 -> 0 after 256 ticks.
//   - mode=10 from dout=0: first tick gives 8'h01. Next tick gives 8'hB8, then 8'h5C.
//     The sequence has period 255 and never returns to 0.
//   - mode=11 after load with din=8'h81: ticks give 8'h03, then 8'h06. load and tick in the
//     same cycle gives dout=din_s.
//   - ena low for 10 cycles mid-COUNT: dout, prescaler, and tick are frozen. Counting resumes
//     from the same phase.
//   - IO_PATTERN_IRQ_EN defined, din toggles bit 3 once: exactly one irq pulse. Undefined:
//     irq stays 0.

Source files
------------

// File: rtl/io_pattern_engine.sv
// io_pattern_engine
//   Registered pattern generator between the pad input bus and the pad output bus.
//   The input bus passes through a SYNC_STAGES-deep synchroniser and becomes din_s.
//   dout is driven in one of four modes: invert, count, LFSR, or rotate.
//   A shared prescaler paces the three stepping modes.
//   Optional input-change interrupt: define IO_PATTERN_IRQ_EN to build it.
//   Without the macro, irq is tied low and none of its flops exist.
//
//   mode    | meaning
//   --------+-----------------------------------------------------------
//   INVERT  | dout follows ~din_s every enabled cycle
//   COUNT   | dout increments by one on each prescaler tick
//   LFSR    | dout takes one Galois LFSR step (TAPS) on each tick
//   ROTATE  | dout rotates left by one on each tick
//
//   Priority within an enabled cycle:
//     1) load
//     2) mode change (dout holds and the prescaler restarts)
//     3) mode action

module io_pattern_engine #(
    parameter int               WIDTH       = 8,
    parameter int               DIV         = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] TAPS        = 8'hB8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    input  logic             load,
    output logic [WIDTH-1:0] dout,
    output logic             tick,
    output logic             irq
);

    localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_INVERT = 2'b00,
        MODE_COUNT  = 2'b01,
        MODE_LFSR   = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] din_s;

    logic [CW-1:0]    cnt_q, cnt_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic             mode_chg;
    logic             wrap;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] rot_next;
    logic [WIDTH-1:0] cnt_next;

    // Synchroniser shift chain; runs regardless of ena.
    always_comb begin
        sync_d = sync_q;
        sync_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign din_s = sync_q[SYNC_STAGES-1];

    // Next value for each stepping mode.
    // An all-zero LFSR would lock up, so it is kicked to 1.
    always_comb begin
        cnt_next  = dout_q + WIDTH'(1);
        rot_next  = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
        if (dout_q == '0) begin
            lfsr_next = WIDTH'(1);
        end else begin
            lfsr_next = (dout_q >> 1) ^ (dout_q[0] ? TAPS : '0);
        end
    end

    // Prescaler, mode register, and output update.
    always_comb begin
        mode_chg = (mode_e'(mode) != mode_q);
        wrap     = (cnt_q == CNT_LAST);
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        dout_d   = dout_q;
        if (ena) begin
            mode_d = mode_e'(mode);
            if (mode_chg || wrap) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            if (load) begin
                dout_d = din_s;
            end else if (!mode_chg) begin
                case (mode_q)
                    MODE_INVERT: dout_d = ~din_s;
                    MODE_COUNT:  if (wrap) dout_d = cnt_next;
                    MODE_LFSR:   if (wrap) dout_d = lfsr_next;
                    MODE_ROTATE: if (wrap) dout_d = rot_next;
                    default:     dout_d = dout_q;
                endcase
            end
        end
    end

    // State registers; reset lands everything at once, so no partial step survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            cnt_q  <= '0;
            mode_q <= MODE_INVERT;
            dout_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
    // rst_n is included so that a DIV=1 build does not pulse tick while in reset.
    assign tick = ena & rst_n & wrap;

`ifdef IO_PATTERN_IRQ_EN
    logic [WIDTH-1:0] din_prev_q, din_prev_d;
    logic             irq_q, irq_d;

    // Previous din_s and the registered change flag.
    always_comb begin
        din_prev_d = din_s;
        irq_d      = ena & (din_s != din_prev_q);
    end

    // Change-detect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_prev_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            din_prev_q <= din_prev_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q & ena;
`else
    assign irq = 1'b0;
`endif

endmodule
